pwm_capture: RTL

- Receive-side counterpart of the PWM channel: measures period and high time of an external PWM waveform on one input pin.
- Sits beside the PWM block in the peripheral cluster. Typical uses: loopback self-test of our own PWM outputs, and tachometer or duty sensing of external devices.
- Results are in prescaled clock ticks and are delivered through a one-entry valid/ready result register.

---
 rtl/pwm_capture_pkg.sv | 22 ++
 rtl/pwm_capture_sync.sv | 32 +++
 rtl/pwm_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types for the PWM capture block: FSM states and the result record.
package pwm_capture_pkg;

    localparam int CntDwDefault = 16;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } pwm_cap_state_e;

    // Fields are sized for the default width; narrower instances zero-extend into them.
    typedef struct packed {
        logic [CntDwDefault-1:0] period;
        logic [CntDwDefault-1:0] high;
        logic                    sat;
        logic                    timeout;
        logic                    level;
    } pwm_cap_meas_t;

endpackage

// File: rtl/pwm_capture_sync.sv
// Two-flop synchroniser for the PWM pin, optional inversion and single-cycle edge pulses.
module pwm_capture_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwm_i,
    input  logic invert_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            meta_q  <= pwm_i;
            sync_q  <= meta_q;
            level_q <= level_o;
        end
    end

    assign level_o = sync_q ^ invert_i;
    assign rise_o  = level_o & ~level_q;
    assign fall_o  = ~level_o & level_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time (rise to fall) in prescaled
// ticks and hands each result over through a one-entry valid/ready register.
//
// state    | meaning
// DISABLED | capture off, counters held at zero
// ARMED    | waiting for a rise; any partial first period is discarded
// HIGH     | line high, high time accumulating
// LOW      | line low, waiting for the rise that closes the period
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CntDw = CntDwDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             invert_i,
    input  logic [CntDw-1:0] clk_div_i,
    input  logic [CntDw-1:0] timeout_i,
    input  logic             pwm_i,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic [CntDw-1:0] meas_period_o,
    output logic [CntDw-1:0] meas_high_o,
    output logic             meas_sat_o,
    output logic             meas_timeout_o,
    output logic             meas_level_o,
    output logic             drop_o
);

    localparam logic [CntDw-1:0] CntMax = {{(CntDw-1){1'b1}}, 1'b0};

    logic level, rise, fall;

    pwm_capture_sync u_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .pwm_i    (pwm_i),
        .invert_i (invert_i),
        .level_o  (level),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    pwm_cap_state_e   state_q, state_d;
    logic [CntDw-1:0] pre_q, cnt_q, cnt_inc;
    logic [CntDw-1:0] hi_q, hi_d;
    logic             sat_q;
    logic             clear_all, cnt_clr, produce, to_fire, timeout_hit;
    pwm_cap_meas_t    meas_q, meas_new;
    logic             valid_q, drop_q;

    assign cnt_inc     = cnt_q + CntDw'(1);
    assign clear_all   = clr_i | ~en_i;
    assign timeout_hit = (timeout_i != '0) && (cnt_inc >= timeout_i);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        cnt_clr  = 1'b0;
        produce  = 1'b0;
        to_fire  = 1'b0;
        meas_new = '0;
        if (clear_all) begin
            state_d = en_i ? ARMED : DISABLED;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                DISABLED: begin
                    state_d = ARMED;
                    cnt_clr = 1'b1;
                end
                ARMED: begin
                    cnt_clr = rise | fall;
                    if (rise) state_d = HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        hi_d    = cnt_inc;
                        state_d = LOW;
                    end else if (timeout_hit) begin
                        to_fire = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        produce         = 1'b1;
                        cnt_clr         = 1'b1;
                        meas_new.period = CntDwDefault'(cnt_inc);
                        meas_new.high   = CntDwDefault'(hi_q);
                        meas_new.sat    = sat_q;
                        state_d         = HIGH;
                    end else if (timeout_hit) begin
                        to_fire = 1'b1;
                    end
                end
                default: state_d = DISABLED;
            endcase
            // A timeout record carries only the line level; period and high stay zero.
            if (to_fire) begin
                produce          = 1'b1;
                cnt_clr          = 1'b1;
                meas_new.timeout = 1'b1;
                meas_new.level   = level;
                state_d          = ARMED;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DISABLED;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    // Counter saturates one below all-ones so the reported cnt+1 never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (cnt_clr) begin
            pre_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (pre_q >= clk_div_i) begin
            pre_q <= '0;
            if (cnt_q == CntMax) sat_q <= 1'b1;
            else                 cnt_q <= cnt_inc;
        end else begin
            pre_q <= pre_q + CntDw'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            meas_q  <= '0;
        end else begin
            if (clr_i) drop_q <= 1'b0;
            if (clear_all) begin
                valid_q <= 1'b0;
            end else if (produce) begin
                if (!valid_q || meas_ready_i) begin
                    valid_q <= 1'b1;
                    meas_q  <= meas_new;
                end else begin
                    drop_q <= 1'b1;
                end
            end else if (meas_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign meas_valid_o   = valid_q;
    assign meas_period_o  = meas_q.period[CntDw-1:0];
    assign meas_high_o    = meas_q.high[CntDw-1:0];
    assign meas_sat_o     = meas_q.sat;
    assign meas_timeout_o = meas_q.timeout;
    assign meas_level_o   = meas_q.level;
    assign drop_o         = drop_q;

endmodule
